// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, drives the asynchronous-read
// instruction memory and registers each fetched word into IF/ID with a
// valid flag. Handles decode stalls, branch/jump redirects and a halt word.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] InstAddress,
  input  logic [31:0] InstData,
  output logic [31:0] InstrOut,
  output logic [31:0] PCPlus4Out,
  output logic        ValidOut,
  output logic        Halted,
  output logic        MisalignErr,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] pc_plus4;

  // The memory read is combinational, so the word for PC is on InstData now.
  assign InstAddress = pc_q;
  assign pc_plus4    = pc_q + 32'd4;

  assign InstrOut    = instr_q;
  assign PCPlus4Out  = pc_plus4_q;
  assign ValidOut    = valid_q;
  assign Halted      = (state_q == ST_HALT);
  assign MisalignErr = misalign_q;
  assign FetchCount  = fetch_count_q;

  // Next-state and IF/ID update: Redirect beats Stall beats a normal fetch.
  always_comb begin
    // NOTE: every _d starts as its _q so no path leaves a value unassigned;
    // a missing default here would infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_plus4_d    = pc_plus4_q;
    valid_d       = valid_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
        end
      end

      ST_RUN: begin
        if (Redirect) begin
          // Flush the wrong-path word; low address bits are dropped.
          pc_d       = {RedirectTarget[31:2], 2'b00};
          valid_d    = 1'b0;
          instr_d    = 32'd0;
          pc_plus4_d = 32'd0;
          if (RedirectTarget[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
        end else if (!Stall) begin
          instr_d       = InstData;
          pc_plus4_d    = pc_plus4;
          valid_d       = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          if (InstData == HALT_WORD) begin
            // Halt word is delivered and counted, but the PC stops on it.
            state_d = ST_HALT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      ST_HALT: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = RESET_PC;
          valid_d = 1'b0;
        end else if (!Stall) begin
          // Halt word stays visible only while decode is stalled on it.
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and IF/ID registers with immediate asynchronous clear.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'd0;
      pc_plus4_q    <= 32'd0;
      valid_q       <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_plus4_q    <= pc_plus4_d;
      valid_q       <= valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural instruction memory
// holding i*3 at word i and the halt word at word 5.
module tb_fetch_sequencer;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] InstAddress;
  logic [31:0] InstData;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic        ValidOut;
  logic        Halted;
  logic        MisalignErr;
  logic [31:0] FetchCount;

  logic [31:0] mem [1024];

  int n_total;
  int n_bad;

  fetch_sequencer dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .Start          (Start),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .InstAddress    (InstAddress),
    .InstData       (InstData),
    .InstrOut       (InstrOut),
    .PCPlus4Out     (PCPlus4Out),
    .ValidOut       (ValidOut),
    .Halted         (Halted),
    .MisalignErr    (MisalignErr),
    .FetchCount     (FetchCount)
  );

  assign InstData = mem[InstAddress[11:2]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc4, input logic valid);
    check({tag, ".instr"}, InstrOut, instr);
    check({tag, ".pc4"}, PCPlus4Out, pc4);
    check({tag, ".valid"}, {31'd0, ValidOut}, {31'd0, valid});
  endtask

  task automatic check_cleared(input string tag);
    check_ifid(tag, 32'd0, 32'd0, 1'b0);
    check({tag, ".addr"}, InstAddress, 32'd0);
    check({tag, ".halted"}, {31'd0, Halted}, 32'd0);
    check({tag, ".misalign"}, {31'd0, MisalignErr}, 32'd0);
    check({tag, ".count"}, FetchCount, 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int i = 0; i < 1024; i++) mem[i] = i * 3;
    mem[5] = 32'hFFFF_FFFF;

    Rst = 1'b1; Start = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 32'd0;
    #12;
    check_cleared("reset");
    Rst = 1'b0;
    tick();
    check("idle.valid", {31'd0, ValidOut}, 32'd0);

    // Start pulse, then four unstalled fetches.
    Start = 1'b1; tick(); Start = 1'b0;
    check("start.addr", InstAddress, 32'd0);
    check("start.valid", {31'd0, ValidOut}, 32'd0);
    tick(); check_ifid("f0", 32'd0, 32'd4, 1'b1);
    tick(); check_ifid("f1", 32'd3, 32'd8, 1'b1);
    tick(); check_ifid("f2", 32'd6, 32'd12, 1'b1);
    check("f2.addr", InstAddress, 32'd12);

    // Hold for three cycles while InstrOut=6.
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_ifid("stall", 32'd6, 32'd12, 1'b1);
      check("stall.addr", InstAddress, 32'd12);
      check("stall.count", FetchCount, 32'd3);
    end
    Stall = 1'b0;
    tick(); check_ifid("f3", 32'd9, 32'd16, 1'b1);
    check("f3.count", FetchCount, 32'd4);

    // Redirect beats a simultaneous stall.
    Redirect = 1'b1; RedirectTarget = 32'h40; Stall = 1'b1;
    tick();
    Redirect = 1'b0; Stall = 1'b0;
    check_ifid("redir", 32'd0, 32'd0, 1'b0);
    check("redir.addr", InstAddress, 32'h40);
    check("redir.misalign", {31'd0, MisalignErr}, 32'd0);
    tick(); check_ifid("redir.first", 32'd48, 32'h44, 1'b1);
    check("redir.count", FetchCount, 32'd5);

    // Misaligned target: aligned PC, sticky error.
    Redirect = 1'b1; RedirectTarget = 32'h43;
    tick();
    Redirect = 1'b0; Stall = 1'b1;
    check("mis.addr", InstAddress, 32'h40);
    check("mis.flag", {31'd0, MisalignErr}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    check("mis.sticky", {31'd0, MisalignErr}, 32'd1);
    check("mis.count", FetchCount, 32'd5);

    // Run into the halt word at word 5.
    Stall = 1'b0; Redirect = 1'b1; RedirectTarget = 32'h0C;
    tick();
    Redirect = 1'b0;
    check("h.addr", InstAddress, 32'h0C);
    tick(); check_ifid("h3", 32'd9, 32'h10, 1'b1);
    tick(); check_ifid("h4", 32'd12, 32'h14, 1'b1);
    tick(); check_ifid("halt", 32'hFFFF_FFFF, 32'h18, 1'b1);
    check("halt.halted", {31'd0, Halted}, 32'd1);
    check("halt.addr", InstAddress, 32'h14);
    check("halt.count", FetchCount, 32'd8);
    Stall = 1'b1;
    tick(); check_ifid("halt.stall", 32'hFFFF_FFFF, 32'h18, 1'b1);
    Stall = 1'b0;
    tick();
    check("halt.drop", {31'd0, ValidOut}, 32'd0);
    check("halt.addr2", InstAddress, 32'h14);
    Redirect = 1'b1; RedirectTarget = 32'h80;
    tick();
    Redirect = 1'b0;
    check("halt.redir.addr", InstAddress, 32'h14);
    check("halt.redir.halted", {31'd0, Halted}, 32'd1);
    check("halt.redir.valid", {31'd0, ValidOut}, 32'd0);

    // Restart from HALT; count is preserved.
    Start = 1'b1; tick(); Start = 1'b0;
    check("restart.halted", {31'd0, Halted}, 32'd0);
    check("restart.addr", InstAddress, 32'd0);
    check("restart.valid", {31'd0, ValidOut}, 32'd0);
    check("restart.count", FetchCount, 32'd8);
    tick(); check_ifid("rf0", 32'd0, 32'd4, 1'b1);
    check("rf0.count", FetchCount, 32'd9);
    tick(); check_ifid("rf1", 32'd3, 32'd8, 1'b1);

    // Asynchronous reset mid-cycle: clears before the next edge.
    @(posedge Clk); #3;
    Rst = 1'b1;
    #1;
    check_cleared("arst");
    Rst = 1'b0;
    tick(); tick();
    check("arst.idle.addr", InstAddress, 32'd0);
    check("arst.idle.valid", {31'd0, ValidOut}, 32'd0);
    check("arst.idle.count", FetchCount, 32'd0);
    Start = 1'b1; tick(); Start = 1'b0;
    tick(); check_ifid("arst.f0", 32'd0, 32'd4, 1'b1);
    check("arst.count", FetchCount, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
